// File: rtl/rf_write_arbiter.sv
// Two-port register-file write arbiter: mem has fixed priority, ex is boosted
// after STARVE_LIMIT lost cycles. One-cycle registered output stage.
module rf_write_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        ex_valid,
   input  logic [4:0]  ex_addr,
   input  logic [31:0] ex_data,
   output logic        ex_ready,
   input  logic        mem_valid,
   input  logic [4:0]  mem_addr,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   output logic        rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_wdata,
   output logic [15:0] wr_count
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]  starve_cnt;
   logic        allow;
   logic        ex_win;
   logic        accept;
   logic [4:0]  sel_addr;
   logic [31:0] sel_data;

   // ex wins when it is alone or has lost LIMIT times in a row
   always_comb begin
      allow     = !rst && !stall;
      ex_win    = ex_valid && (!mem_valid || starve_cnt == LIMIT);
      ex_ready  = allow && ex_win;
      mem_ready = allow && mem_valid && !ex_win;
      accept    = ex_ready || mem_ready;
      sel_addr  = ex_ready ? ex_addr : mem_addr;
      sel_data  = ex_ready ? ex_data : mem_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (ex_ready) begin
         starve_cnt <= '0;
      end else if (ex_valid && !stall && starve_cnt != 4'hF) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // x0 writes are consumed but never reach the register file
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_addr  <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= accept && (sel_addr != 5'd0);
         if (accept) begin
            rf_addr  <= sel_addr;
            rf_wdata <= sel_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_count <= '0;
      end else if (rf_we && wr_count != 16'hFFFF) begin
         wr_count <= wr_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: single write, contention, x0, stall,
// mid-stream reset and wr_count saturation.
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        ex_valid;
   logic [4:0]  ex_addr;
   logic [31:0] ex_data;
   logic        ex_ready;
   logic        mem_valid;
   logic [4:0]  mem_addr;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wdata;
   logic [15:0] wr_count;

   int tests = 0;
   int fails = 0;

   rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .ex_valid  (ex_valid),
      .ex_addr   (ex_addr),
      .ex_data   (ex_data),
      .ex_ready  (ex_ready),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_wdata  (rf_wdata),
      .wr_count  (wr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ready(input string tag, input int exr, input int memr);
      chk({tag, "_ex_ready"}, 32'(ex_ready), 32'(exr));
      chk({tag, "_mem_ready"}, 32'(mem_ready), 32'(memr));
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0;
      ex_valid = 1'b1; ex_addr = 5'd1; ex_data = 32'h1111_1111;
      mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h2222_2222;
      #1;
      chk_ready("in_reset", 0, 0);
      tick();
      chk("rst_rf_we", 32'(rf_we), 0);
      chk("rst_rf_addr", 32'(rf_addr), 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_wr_count", 32'(wr_count), 0);
      chk("rst_starve", 32'(dut.starve_cnt), 0);
      ex_valid = 1'b0; mem_valid = 1'b0;
      rst = 1'b0;

      // single ex write
      ex_valid = 1'b1; ex_addr = 5'd5; ex_data = 32'hDEAD_BEEF;
      #1;
      chk_ready("single", 1, 0);
      tick();
      ex_valid = 1'b0;
      chk("single_rf_we", 32'(rf_we), 1);
      chk("single_rf_addr", 32'(rf_addr), 5);
      chk("single_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
      chk("single_cnt_pre", 32'(wr_count), 0);
      tick();
      chk("single_cnt", 32'(wr_count), 1);
      chk("single_we_off", 32'(rf_we), 0);

      // contention: mem wins 4 times, then ex
      ex_valid = 1'b1; ex_addr = 5'd7; ex_data = 32'hE0E0_0007;
      mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'hA5A5_0009;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_ready("contend_mem", 0, 1);
         tick();
         chk("contend_mem_addr", 32'(rf_addr), 9);
         chk("contend_starve", 32'(dut.starve_cnt), 32'(i + 1));
      end
      chk_ready("contend_ex", 1, 0);
      tick();
      chk("contend_ex_addr", 32'(rf_addr), 7);
      chk("contend_ex_data", rf_wdata, 32'hE0E0_0007);
      chk("contend_starve_clr", 32'(dut.starve_cnt), 0);
      chk("contend_cnt", 32'(wr_count), 5);
      ex_valid = 1'b0; mem_valid = 1'b0;
      tick();
      chk("contend_cnt_final", 32'(wr_count), 6);

      // x0 write is consumed but not committed
      mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h0BAD_0000;
      #1;
      chk_ready("x0", 0, 1);
      tick();
      mem_valid = 1'b0;
      chk("x0_rf_we", 32'(rf_we), 0);
      tick();
      chk("x0_cnt", 32'(wr_count), 6);

      // stall with both valid; in-flight write still commits
      ex_valid = 1'b1; ex_addr = 5'd7;
      mem_valid = 1'b1; mem_addr = 5'd9;
      tick();
      chk("pre_stall_starve", 32'(dut.starve_cnt), 1);
      stall = 1'b1;
      #1;
      chk_ready("stall0", 0, 0);
      chk("stall_inflight_we", 32'(rf_we), 1);
      tick();
      chk("stall_commit_cnt", 32'(wr_count), 7);
      for (int i = 0; i < 2; i++) begin
         chk_ready("stall", 0, 0);
         tick();
         chk("stall_rf_we", 32'(rf_we), 0);
         chk("stall_starve", 32'(dut.starve_cnt), 1);
      end
      chk("stall_cnt_hold", 32'(wr_count), 7);
      stall = 1'b0;

      // reset during back-to-back grants
      tick();
      tick();
      chk("b2b_rf_we", 32'(rf_we), 1);
      rst = 1'b1;
      #1;
      chk_ready("midrst", 0, 0);
      tick();
      chk("midrst_rf_we", 32'(rf_we), 0);
      chk("midrst_cnt", 32'(wr_count), 0);
      chk("midrst_rf_addr", 32'(rf_addr), 0);
      chk("midrst_starve", 32'(dut.starve_cnt), 0);
      chk_ready("midrst_hold", 0, 0);
      tick();
      chk("midrst_cnt2", 32'(wr_count), 0);
      ex_valid = 1'b0;
      mem_addr = 5'd3; mem_data = 32'h0000_0003;
      rst = 1'b0;

      // saturation: continuous mem writes
      repeat (1000) tick();
      chk("sat_partial", 32'(wr_count), 999);
      repeat (65000) tick();
      chk("sat_reach", 32'(wr_count), 32'hFFFF);
      mem_valid = 1'b0;
      tick();
      tick();
      chk("sat_hold", 32'(wr_count), 32'hFFFF);
      chk("sat_we_off", 32'(rf_we), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive lost-arbitration cycles after which ex wins the next grant; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 stall  input  1  SHALL be a global hold; while high, no request is accepted.
REQ-005 ex_valid  input  1  SHALL flag an execute-stage write request.
REQ-006 ex_addr  input  5  SHALL be the execute destination register.
REQ-007 ex_data  input  32  SHALL be the execute write data.
REQ-008 ex_ready  output  1  SHALL signal acceptance of the ex request this cycle.
REQ-009 mem_valid, mem_addr[4:0], mem_data[31:0]  input  SHALL be the memory-stage request, with the same meanings as the ex inputs.
REQ-010 mem_ready  output  1  SHALL signal acceptance of the mem request this cycle.
REQ-011 rf_we  output  1  SHALL drive the register-file write enable.
REQ-012 rf_addr  output  5  SHALL drive the register-file write address.
REQ-013 rf_wdata  output  32  SHALL drive the register-file write data.
REQ-014 wr_count  output  16  SHALL count committed register-file writes; it saturates at 16'hFFFF.

Function
REQ-015 A request SHALL be accepted at a posedge where its valid and ready are both 1; requesters hold addr/data stable while valid=1 and ready=0.
REQ-016 ex_ready and mem_ready SHALL be combinational; at most one is 1 in any cycle; both are 0 when rst=1 or stall=1.
REQ-017 Arbitration SHALL use fixed priority to mem; when both are valid, mem wins unless starve_cnt==STARVE_LIMIT, in which case ex wins.
REQ-018 When only one requester is valid, that requester SHALL be granted, regardless of starve_cnt.
REQ-019 starve_cnt (4 bit) SHALL increment when ex_valid=1, stall=0 and ex is not granted; it clears to 0 when ex is accepted and holds when ex_valid=0 or stall=1.
REQ-020 On acceptance at edge N, the output stage SHALL register the address and data, so rf_we/rf_addr/rf_wdata are valid for cycle N..N+1 and the register file commits at edge N+1; latency is one cycle.
REQ-021 The output stage SHALL drain every cycle, so one write per cycle is sustained: back-to-back grants produce rf_we=1 on consecutive cycles.
REQ-022 A cycle with no acceptance SHALL load rf_we=0; rf_addr and rf_wdata hold their previous values.
REQ-023 An accepted request with addr==0 SHALL be consumed and SHALL count as a grant for starve_cnt, but it loads rf_we=0 and does not increment wr_count.
REQ-024 wr_count SHALL increment at each edge where rf_we=1, saturating at 16'hFFFF.
REQ-025 Both requesters valid with the same addr SHALL be serialized per REQ-017 (no merging); the later grant's data is the final register value.
REQ-026 stall asserted while rf_we=1 SHALL NOT cancel that in-flight write; it commits at the next edge.

Reset
REQ-027 When rst=1 at a posedge, rf_we, rf_addr, rf_wdata, starve_cnt and wr_count SHALL all become 0.
REQ-028 While rst=1, ex_ready and mem_ready SHALL be 0; an in-flight write at reset assertion is discarded.
REQ-029 The first acceptance SHALL occur no earlier than the first posedge with rst=0.

Verification
REQ-030 The bench SHALL cover: single-ex: ex_valid=1, addr=5, data=32'hDEAD_BEEF at edge 1 -> ex_ready=1 in cycle 0; rf_we=1, rf_addr=5, rf_wdata=32'hDEAD_BEEF in cycle 1; wr_count=1 after edge 2.
REQ-031 The bench SHALL cover: contention: both valid continuously, STARVE_LIMIT=4 -> mem granted 4 consecutive cycles, ex granted on the 5th, starve_cnt returns to 0.
REQ-032 The bench SHALL cover: x0: mem_valid=1, addr=0 -> mem_ready=1, next cycle rf_we=0, wr_count unchanged.
REQ-033 The bench SHALL cover: stall: stall=1 for 3 cycles with both valid -> both readies 0, rf_we=0 after the first cycle, starve_cnt unchanged.
REQ-034 The bench SHALL cover: reset mid-stream: rst=1 during back-to-back grants -> after the edge, rf_we=0, wr_count=0, and both readies are 0 until rst=0.
REQ-035 The bench SHALL cover: saturation: force 65536 writes -> wr_count holds at 16'hFFFF.
